// File: rtl/atm_session_ctrl_pkg.sv
// rtl/atm_session_ctrl_pkg.sv - opcodes, response codes and FSM states for the ATM session controller
package atm_pkg;

  localparam logic [2:0] OP_BAL  = 3'b001;
  localparam logic [2:0] OP_WD   = 3'b010;
  localparam logic [2:0] OP_DEP  = 3'b011;
  localparam logic [2:0] OP_XFER = 3'b100;
  localparam logic [2:0] OP_PIN  = 3'b101;
  localparam logic [2:0] OP_END  = 3'b110;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_ACCT    = 3'd1;
  localparam logic [2:0] ERR_LOCK    = 3'd2;
  localparam logic [2:0] ERR_FUNDS   = 3'd3;
  localparam logic [2:0] ERR_OVF     = 3'd4;
  localparam logic [2:0] ERR_OP      = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT = 3'd6;
  localparam logic [2:0] ERR_LIMIT   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIN_WAIT,
    S_MENU,
    S_EXEC,
    S_RESULT,
    S_EJECT
  } state_t;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// rtl/atm_session_ctrl_if.sv - card, PIN, transaction and response signals of the ATM session controller
interface atm_session_ctrl_if #(
  parameter int AW    = 3,
  parameter int AMT_W = 19,
  parameter int BAL_W = 19,
  parameter int PIN_W = 16
);
  logic             card_in;
  logic [AW-1:0]    card_acct;
  logic             pin_valid;
  logic [PIN_W-1:0] pin_in;
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       opcode;
  logic [AMT_W-1:0] amount;
  logic [AW-1:0]    dest_acct;
  logic [PIN_W-1:0] new_pin;
  logic             rsp_valid;
  logic [2:0]       rsp_err;
  logic [BAL_W-1:0] balance_out;
  logic             card_eject;
  logic             card_retain;
  logic             session_busy;

  modport master (
    output card_in, card_acct, pin_valid, pin_in, op_valid, opcode, amount, dest_acct, new_pin,
    input  op_ready, rsp_valid, rsp_err, balance_out, card_eject, card_retain, session_busy
  );

  modport slave (
    input  card_in, card_acct, pin_valid, pin_in, op_valid, opcode, amount, dest_acct, new_pin,
    output op_ready, rsp_valid, rsp_err, balance_out, card_eject, card_retain, session_busy
  );
endinterface

// File: rtl/atm_session_ctrl_acct_bank.sv
// rtl/atm_session_ctrl_acct_bank.sv - banked balance/PIN/lock registers with self and dest ports
module atm_acct_bank #(
  parameter int          NUM_ACCTS = 8,
  parameter int          AW        = 3,
  parameter int          BAL_W     = 19,
  parameter int          PIN_W     = 16,
  parameter int unsigned INIT_BAL  = 1000,
  parameter int unsigned PIN_BASE  = 'h1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    self_addr,
  input  logic [AW-1:0]    dest_addr,
  output logic [BAL_W-1:0] self_bal,
  output logic [PIN_W-1:0] self_pin,
  output logic             self_lock,
  output logic [BAL_W-1:0] dest_bal,
  input  logic             self_bal_we,
  input  logic [BAL_W-1:0] self_bal_wdata,
  input  logic             dest_bal_we,
  input  logic [BAL_W-1:0] dest_bal_wdata,
  input  logic             pin_we,
  input  logic [PIN_W-1:0] pin_wdata,
  input  logic             lock_set
);
  localparam logic [AW:0] ACCT_LIM = (AW+1)'(NUM_ACCTS);

  logic [BAL_W-1:0] bal_q  [NUM_ACCTS];
  logic [PIN_W-1:0] pin_q  [NUM_ACCTS];
  logic             lock_q [NUM_ACCTS];

  logic self_ok;
  logic dest_ok;

  assign self_ok   = ({1'b0, self_addr} < ACCT_LIM);
  assign dest_ok   = ({1'b0, dest_addr} < ACCT_LIM);
  assign self_bal  = self_ok ? bal_q[self_addr]  : '0;
  assign self_pin  = self_ok ? pin_q[self_addr]  : '0;
  assign self_lock = self_ok ? lock_q[self_addr] : 1'b0;
  assign dest_bal  = dest_ok ? bal_q[dest_addr]  : '0;

  // Both balance writes land on the same edge so a transfer is never half-applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal_q[i]  <= BAL_W'(INIT_BAL);
        pin_q[i]  <= PIN_W'(PIN_BASE + i);
        lock_q[i] <= 1'b0;
      end
    end else begin
      if (self_bal_we) bal_q[self_addr]  <= self_bal_wdata;
      if (dest_bal_we) bal_q[dest_addr]  <= dest_bal_wdata;
      if (pin_we)      pin_q[self_addr]  <= pin_wdata;
      if (lock_set)    lock_q[self_addr] <= 1'b1;
    end
  end
endmodule

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - multi-account ATM session FSM with PIN lockout, timeout and transfers
// ATM_DAILY_LIMIT_EN adds a per-session withdraw cap of WD_LIMIT.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int          NUM_ACCTS   = 8,
  parameter int          BAL_W       = 19,
  parameter int          AMT_W       = 19,
  parameter int          PIN_W       = 16,
  parameter int          MAX_TRIES   = 3,
  parameter int          TIMEOUT_CYC = 1000,
  parameter int unsigned INIT_BAL    = 1000,
  parameter int unsigned PIN_BASE    = 'h1000,
  parameter int unsigned WD_LIMIT    = 5000
) (
  input logic               clk,
  input logic               reset,
  atm_session_ctrl_if.slave bus
);
  localparam int AW  = $clog2(NUM_ACCTS);
  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int TMW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0]    ACCT_LIM  = (AW+1)'(NUM_ACCTS);
  localparam logic [TRW-1:0] TRY_LAST  = TRW'(MAX_TRIES - 1);
  localparam logic [TMW-1:0] TIME_LAST = TMW'(TIMEOUT_CYC - 1);

  state_t state_q, state_d;

  logic [AW-1:0]    acct_q, dest_q;
  logic [2:0]       opc_q;
  logic [AMT_W-1:0] amt_q;
  logic [PIN_W-1:0] npin_q;
  logic [TRW-1:0]   tries_q;
  logic [TMW-1:0]   timer_q;
  logic             hold_q;

  logic             rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_err_q, rsp_err_d;
  logic [BAL_W-1:0] bal_out_q, bal_out_d;
  logic             eject_q, eject_d;
  logic             retain_q, retain_d;

  logic start_sess, pin_miss, lock_set, handshake, commit, timer_run, timer_hit;

  logic [AW-1:0]    rd_addr;
  logic [BAL_W-1:0] self_bal, dest_bal;
  logic [PIN_W-1:0] self_pin;
  logic             self_lock;

  logic [2:0]       ex_err;
  logic             ex_self_we, ex_dest_we, ex_pin_we;
  logic [BAL_W-1:0] ex_self_bal, ex_dest_bal;
  logic [BAL_W-1:0] amt_ext;
  logic [BAL_W:0]   self_sum, dest_sum;

`ifdef ATM_DAILY_LIMIT_EN
  localparam logic [BAL_W+1:0] WD_CAP = (BAL_W+2)'(WD_LIMIT);
  logic [BAL_W:0]   wd_acc_q;
  logic [BAL_W+1:0] wd_sum;
  assign wd_sum = {1'b0, wd_acc_q} + (BAL_W+2)'(amt_q);
`else
  logic unused_wd_limit;
  assign unused_wd_limit = ^((BAL_W+2)'(WD_LIMIT));
`endif

  // In IDLE the self port looks at the card being inserted so the lock flag is checked before PIN entry.
  assign rd_addr = (state_q == S_IDLE) ? bus.card_acct : acct_q;

  atm_acct_bank #(
    .NUM_ACCTS(NUM_ACCTS), .AW(AW), .BAL_W(BAL_W), .PIN_W(PIN_W),
    .INIT_BAL(INIT_BAL), .PIN_BASE(PIN_BASE)
  ) u_bank (
    .clk(clk), .reset(reset),
    .self_addr(rd_addr), .dest_addr(dest_q),
    .self_bal(self_bal), .self_pin(self_pin), .self_lock(self_lock), .dest_bal(dest_bal),
    .self_bal_we(commit & ex_self_we), .self_bal_wdata(ex_self_bal),
    .dest_bal_we(commit & ex_dest_we), .dest_bal_wdata(ex_dest_bal),
    .pin_we(commit & ex_pin_we), .pin_wdata(npin_q),
    .lock_set(lock_set)
  );

  assign amt_ext  = BAL_W'(amt_q);
  assign self_sum = {1'b0, self_bal} + {1'b0, amt_ext};
  assign dest_sum = {1'b0, dest_bal} + {1'b0, amt_ext};

  // Any error leaves every write enable low, which keeps transfers atomic.
  always_comb begin
    ex_err      = ERR_OK;
    ex_self_we  = 1'b0;
    ex_dest_we  = 1'b0;
    ex_pin_we   = 1'b0;
    ex_self_bal = self_bal;
    ex_dest_bal = dest_sum[BAL_W-1:0];
    case (opc_q)
      OP_BAL, OP_END: begin
      end
      OP_WD: begin
        if (amt_ext > self_bal) ex_err = ERR_FUNDS;
`ifdef ATM_DAILY_LIMIT_EN
        else if (wd_sum > WD_CAP) ex_err = ERR_LIMIT;
`endif
        else begin
          ex_self_we  = 1'b1;
          ex_self_bal = self_bal - amt_ext;
        end
      end
      OP_DEP: begin
        if (self_sum[BAL_W]) ex_err = ERR_OVF;
        else begin
          ex_self_we  = 1'b1;
          ex_self_bal = self_sum[BAL_W-1:0];
        end
      end
      OP_XFER: begin
        if (({1'b0, dest_q} >= ACCT_LIM) || (dest_q == acct_q)) ex_err = ERR_ACCT;
        else if (amt_ext > self_bal) ex_err = ERR_FUNDS;
        else if (dest_sum[BAL_W]) ex_err = ERR_OVF;
        else begin
          ex_self_we  = 1'b1;
          ex_dest_we  = 1'b1;
          ex_self_bal = self_bal - amt_ext;
        end
      end
      OP_PIN:  ex_pin_we = 1'b1;
      default: ex_err = ERR_OP;
    endcase
  end

  assign timer_run = (state_q == S_PIN_WAIT) || (state_q == S_MENU);
  assign timer_hit = (timer_q == TIME_LAST);
  assign handshake = (state_q == S_MENU) && bus.card_in && bus.op_valid;
  assign commit    = (state_q == S_EXEC) && bus.card_in;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = ERR_OK;
    bal_out_d   = '0;
    eject_d     = 1'b0;
    retain_d    = 1'b0;
    start_sess  = 1'b0;
    pin_miss    = 1'b0;
    lock_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.card_in && !hold_q) begin
          if ({1'b0, bus.card_acct} >= ACCT_LIM) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_ACCT;
            eject_d     = 1'b1;
            state_d     = S_EJECT;
          end else if (self_lock) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_LOCK;
            eject_d     = 1'b1;
            state_d     = S_EJECT;
          end else begin
            start_sess = 1'b1;
            state_d    = S_PIN_WAIT;
          end
        end
      end
      S_PIN_WAIT: begin
        if (!bus.card_in) state_d = S_IDLE;
        else if (bus.pin_valid) begin
          if (bus.pin_in == self_pin) state_d = S_MENU;
          else if (tries_q == TRY_LAST) begin
            lock_set    = 1'b1;
            retain_d    = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_LOCK;
            state_d     = S_IDLE;
          end else pin_miss = 1'b1;
        end else if (timer_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          eject_d     = 1'b1;
          state_d     = S_EJECT;
        end
      end
      S_MENU: begin
        if (!bus.card_in) state_d = S_IDLE;
        else if (bus.op_valid) state_d = S_EXEC;
        else if (timer_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          eject_d     = 1'b1;
          state_d     = S_EJECT;
        end
      end
      S_EXEC: begin
        if (!bus.card_in) state_d = S_IDLE;
        else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = ex_err;
          bal_out_d   = ex_self_bal;
          eject_d     = (opc_q == OP_END);
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (!bus.card_in) state_d = S_IDLE;
        else if (opc_q == OP_END) state_d = S_EJECT;
        else state_d = S_MENU;
      end
      S_EJECT: begin
        if (!bus.card_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acct_q      <= '0;
      dest_q      <= '0;
      opc_q       <= '0;
      amt_q       <= '0;
      npin_q      <= '0;
      tries_q     <= '0;
      timer_q     <= '0;
      hold_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= '0;
      bal_out_q   <= '0;
      eject_q     <= 1'b0;
      retain_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      bal_out_q   <= bal_out_d;
      eject_q     <= eject_d;
      retain_q    <= retain_d;
      if (start_sess) acct_q <= bus.card_acct;
      if (start_sess) tries_q <= '0;
      else if (pin_miss) tries_q <= tries_q + 1'b1;
      if (start_sess) timer_q <= '0;
      else if (timer_run) timer_q <= (bus.pin_valid || handshake) ? '0 : timer_q + 1'b1;
      if (handshake) begin
        opc_q  <= bus.opcode;
        amt_q  <= bus.amount;
        dest_q <= bus.dest_acct;
        npin_q <= bus.new_pin;
      end
      // A retained card must be pulled before IDLE will start another session.
      if (retain_d) hold_q <= 1'b1;
      else if (!bus.card_in) hold_q <= 1'b0;
    end
  end

`ifdef ATM_DAILY_LIMIT_EN
  always_ff @(posedge clk) begin
    if (reset) wd_acc_q <= '0;
    else if (start_sess) wd_acc_q <= '0;
    else if (commit && ex_self_we && (opc_q == OP_WD)) wd_acc_q <= wd_sum[BAL_W:0];
  end
`endif

  assign bus.op_ready     = (state_q == S_MENU);
  assign bus.session_busy = (state_q != S_IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.balance_out  = bal_out_q;
  assign bus.card_eject   = eject_q;
  assign bus.card_retain  = retain_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - directed self-checking bench for atm_session_ctrl
module tb_atm_session_ctrl;
  localparam int AW    = 3;
  localparam int BAL_W = 19;
  localparam int AMT_W = 19;
  localparam int PIN_W = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  atm_session_ctrl_if #(.AW(AW), .AMT_W(AMT_W), .BAL_W(BAL_W), .PIN_W(PIN_W)) bus ();

  atm_session_ctrl #(
    .NUM_ACCTS(8), .BAL_W(BAL_W), .AMT_W(AMT_W), .PIN_W(PIN_W), .MAX_TRIES(3),
    .TIMEOUT_CYC(1000), .INIT_BAL(1000), .PIN_BASE('h1000), .WD_LIMIT(500)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [AW-1:0] acct, input logic [PIN_W-1:0] pin);
    bus.card_in   = 1'b1;
    bus.card_acct = acct;
    tick();
    chk("busy_after_insert", 32'(bus.session_busy), 1);
    bus.pin_valid = 1'b1;
    bus.pin_in    = pin;
    tick();
    bus.pin_valid = 1'b0;
    chk("menu_ready", 32'(bus.op_ready), 1);
  endtask

  task automatic do_op(input string tag, input logic [2:0] opc, input logic [AMT_W-1:0] amt,
                       input logic [AW-1:0] dest, input logic [PIN_W-1:0] npin,
                       input int exp_err, input int exp_bal);
    bus.op_valid  = 1'b1;
    bus.opcode    = opc;
    bus.amount    = amt;
    bus.dest_acct = dest;
    bus.new_pin   = npin;
    tick();
    bus.op_valid = 1'b0;
    chk({tag, "_exec_norsp"}, 32'(bus.rsp_valid), 0);
    tick();
    chk({tag, "_rsp"}, 32'(bus.rsp_valid), 1);
    chk({tag, "_err"}, 32'(bus.rsp_err), exp_err);
    chk({tag, "_bal"}, 32'(bus.balance_out), exp_bal);
    tick();
    chk({tag, "_menu"}, 32'(bus.op_ready), 1);
  endtask

  task automatic end_session(input string tag);
    bus.op_valid = 1'b1;
    bus.opcode   = 3'b110;
    tick();
    bus.op_valid = 1'b0;
    tick();
    chk({tag, "_rsp"}, 32'(bus.rsp_valid), 1);
    chk({tag, "_err"}, 32'(bus.rsp_err), 0);
    chk({tag, "_eject"}, 32'(bus.card_eject), 1);
    tick();
    chk({tag, "_eject_pulse"}, 32'(bus.card_eject), 0);
    chk({tag, "_eject_busy"}, 32'(bus.session_busy), 1);
    bus.card_in = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'(bus.session_busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.card_in   = 1'b0;
    bus.card_acct = '0;
    bus.pin_valid = 1'b0;
    bus.pin_in    = '0;
    bus.op_valid  = 1'b0;
    bus.opcode    = '0;
    bus.amount    = '0;
    bus.dest_acct = '0;
    bus.new_pin   = '0;
    tick();
    tick();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_eject", 32'(bus.card_eject), 0);
    chk("rst_retain", 32'(bus.card_retain), 0);
    chk("rst_busy", 32'(bus.session_busy), 0);
    chk("rst_op_ready", 32'(bus.op_ready), 0);
    chk("rst_balance", 32'(bus.balance_out), 0);
    reset = 1'b0;
    tick();

    // balance enquiry with the N+2 response latency
    start(3'd3, 16'h1003);
    do_op("bal3", 3'b001, 19'd0, 3'd0, 16'h0, 0, 1000);
    end_session("end3");

    // three wrong PINs lock account 2, then reinsertion is refused
    bus.card_in   = 1'b1;
    bus.card_acct = 3'd2;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.pin_valid = 1'b1;
      bus.pin_in    = 16'h0bad;
      tick();
      bus.pin_valid = 1'b0;
      if (i < 2) begin
        chk("wrong_pin_norsp", 32'(bus.rsp_valid), 0);
        chk("wrong_pin_busy", 32'(bus.session_busy), 1);
        tick();
      end
    end
    chk("lock_retain", 32'(bus.card_retain), 1);
    chk("lock_rsp", 32'(bus.rsp_valid), 1);
    chk("lock_err", 32'(bus.rsp_err), 2);
    chk("lock_idle", 32'(bus.session_busy), 0);
    tick();
    chk("retain_pulse", 32'(bus.card_retain), 0);
    chk("hold_idle", 32'(bus.session_busy), 0);
    bus.card_in = 1'b0;
    tick();
    bus.card_in = 1'b1;
    tick();
    chk("locked_rsp", 32'(bus.rsp_valid), 1);
    chk("locked_err", 32'(bus.rsp_err), 2);
    chk("locked_eject", 32'(bus.card_eject), 1);
    bus.card_in = 1'b0;
    tick();
    chk("locked_idle", 32'(bus.session_busy), 0);

    // withdraw above and within balance
    start(3'd1, 16'h1001);
    do_op("wd_over", 3'b010, 19'd1001, 3'd0, 16'h0, 3, 1000);
    do_op("wd_400", 3'b010, 19'd400, 3'd0, 16'h0, 0, 600);
    end_session("end1");

    // transfer 0 -> 5, then self-transfer rejected
    start(3'd0, 16'h1000);
    do_op("xfer_ok", 3'b100, 19'd300, 3'd5, 16'h0, 0, 700);
    do_op("xfer_self", 3'b100, 19'd300, 3'd0, 16'h0, 1, 700);
    end_session("end0");

    // destination credited; deposit carry, bad opcodes, PIN change
    start(3'd5, 16'h1005);
    do_op("bal5", 3'b001, 19'd0, 3'd0, 16'h0, 0, 1300);
    do_op("dep_ovf", 3'b011, 19'd522988, 3'd0, 16'h0, 4, 1300);
    do_op("dep_100", 3'b011, 19'd100, 3'd0, 16'h0, 0, 1400);
    do_op("op_111", 3'b111, 19'd0, 3'd0, 16'h0, 5, 1400);
    do_op("op_000", 3'b000, 19'd0, 3'd0, 16'h0, 5, 1400);
    do_op("pin_chg", 3'b101, 19'd0, 3'd0, 16'hbeef, 0, 1400);
    end_session("end5");
    bus.card_in   = 1'b1;
    bus.card_acct = 3'd5;
    tick();
    bus.pin_valid = 1'b1;
    bus.pin_in    = 16'h1005;
    tick();
    bus.pin_valid = 1'b0;
    chk("old_pin_rejected", 32'(bus.op_ready), 0);
    chk("old_pin_busy", 32'(bus.session_busy), 1);
    bus.pin_valid = 1'b1;
    bus.pin_in    = 16'hbeef;
    tick();
    bus.pin_valid = 1'b0;
    chk("new_pin_accepted", 32'(bus.op_ready), 1);
    end_session("end5b");

    // idle timeout in MENU at exactly TIMEOUT_CYC cycles
    start(3'd4, 16'h1004);
    for (int i = 0; i < 999; i++) tick();
    chk("tmo_not_yet", 32'(bus.rsp_valid), 0);
    chk("tmo_still_menu", 32'(bus.op_ready), 1);
    tick();
    chk("tmo_rsp", 32'(bus.rsp_valid), 1);
    chk("tmo_err", 32'(bus.rsp_err), 6);
    chk("tmo_eject", 32'(bus.card_eject), 1);
    tick();
    bus.card_in = 1'b0;
    tick();
    chk("tmo_idle", 32'(bus.session_busy), 0);

    // card pulled while the withdraw is in EXEC: no response, no commit
    start(3'd6, 16'h1006);
    bus.op_valid = 1'b1;
    bus.opcode   = 3'b010;
    bus.amount   = 19'd100;
    tick();
    bus.op_valid = 1'b0;
    bus.card_in  = 1'b0;
    tick();
    chk("abort_exec_idle", 32'(bus.session_busy), 0);
    chk("abort_exec_norsp", 32'(bus.rsp_valid), 0);
    tick();
    chk("abort_exec_norsp2", 32'(bus.rsp_valid), 0);
    start(3'd6, 16'h1006);
    do_op("abort_bal", 3'b001, 19'd0, 3'd0, 16'h0, 0, 1000);
    end_session("end6");

    // card removal beats a simultaneous op_valid in MENU
    start(3'd7, 16'h1007);
    bus.card_in  = 1'b0;
    bus.op_valid = 1'b1;
    bus.opcode   = 3'b010;
    bus.amount   = 19'd50;
    tick();
    bus.op_valid = 1'b0;
    chk("abort_menu_idle", 32'(bus.session_busy), 0);
    tick();
    chk("abort_menu_norsp", 32'(bus.rsp_valid), 0);

`ifdef ATM_DAILY_LIMIT_EN
    start(3'd3, 16'h1003);
    do_op("lim_300", 3'b010, 19'd300, 3'd0, 16'h0, 0, 700);
    do_op("lim_over", 3'b010, 19'd300, 3'd0, 16'h0, 7, 700);
    end_session("end_lim");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
